// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for DIGITS 7-segment digits sharing one segment bus.
// Hex/BCD decode, leading-zero blanking, anti-ghost blank interval, selectable pin polarity.
module seg7_scan_display #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 1,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_out
);

    localparam int   CW  = $clog2(CLK_DIV);
    localparam int   IW  = $clog2(DIGITS);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [DIGITS-1:0]   upper_zero;
    logic                zero_acc;
    logic [3:0]          cur_nib;
    logic                lz_blank;
    logic [6:0]          seg_raw;
    logic [DIGITS-1:0]   an_raw;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'b0000001;
        case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110010;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1110011;
            4'hA: s = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000001;
            4'hB: s = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000001;
            4'hC: s = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000001;
            4'hD: s = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000001;
            4'hE: s = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000001;
            4'hF: s = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000001;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    // upper_zero[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        upper_zero = '0;
        zero_acc   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc      = zero_acc & (shadow_q[4*i +: 4] == 4'd0);
            upper_zero[i] = zero_acc;
        end
    end

    always_comb begin
        shadow_d    = load ? din   : shadow_q;
        dp_shadow_d = load ? dp_in : dp_shadow_q;

        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        cur_nib  = shadow_q[{idx_q, 2'b00} +: 4];
        lz_blank = lz_en && (idx_q != '0) && upper_zero[idx_q];
        seg_raw  = lz_blank ? 7'b0000000 : decode(cur_nib);
        an_raw   = (cnt_q < CW'(BLANK_CYC)) ? '0 : (DIGITS'(1) << idx_q);

        // Polarity is folded in here so the pins come straight off flops.
        seg_d = seg_raw ^ {7{INV}};
        dp_d  = dp_shadow_q[idx_q] ^ INV;
        an_d  = an_raw ^ {DIGITS{INV}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            dp_shadow_q <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            seg_q       <= {7{INV}};
            dp_q        <= INV;
            an_q        <= {DIGITS{INV}};
        end else begin
            shadow_q    <= shadow_d;
            dp_shadow_q <= dp_shadow_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg_out = seg_q;
    assign dp_out  = dp_q;
    assign an_out  = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: three variants (BCD, hex, active-low) share one stimulus
// stream and are compared every cycle against a tick-count based reference model.
module tb_seg7_scan_display;

    localparam int DIGITS    = 4;
    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;
    localparam int PERIOD    = CLK_DIV * DIGITS;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;

    logic [6:0] seg_b, seg_h, seg_a;
    logic       dp_b, dp_h, dp_a;
    logic [3:0] an_b, an_h, an_a;

    int vectors;
    int miscompares;

    // Reference model state: shadow contents plus cycles elapsed since reset.
    logic [15:0] m_shadow;
    logic [3:0]  m_dp;
    int          m_tick;

    logic [6:0] e_seg_b, e_seg_h;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_rst;

    seg7_scan_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC),
                        .HEX_MODE(0), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .load(load), .lz_en(lz_en),
        .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b));

    seg7_scan_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC),
                        .HEX_MODE(1), .ACTIVE_LOW(0)) dut_hex (
        .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .load(load), .lz_en(lz_en),
        .seg_out(seg_h), .dp_out(dp_h), .an_out(an_h));

    seg7_scan_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC),
                        .HEX_MODE(0), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .load(load), .lz_en(lz_en),
        .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int nib, input bit hex);
        logic [6:0] t [16];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
              7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        if (!hex && nib >= 10) return 7'b0000001;
        return t[nib];
    endfunction

    function automatic int cur_idx();
        return (m_tick / CLK_DIV) % DIGITS;
    endfunction

    function automatic int cur_cnt();
        return m_tick % CLK_DIV;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict from pre-edge state, advance the model, then compare all three DUTs.
    task automatic step();
        int  idx;
        int  nib;
        bit  blank;
        idx   = cur_idx();
        nib   = int'((m_shadow >> (4 * idx)) & 16'hF);
        blank = lz_en && (idx > 0) && ((m_shadow >> (4 * idx)) == 16'd0);
        e_rst = rst;
        if (rst) begin
            e_seg_b = 7'd0; e_seg_h = 7'd0; e_dp = 1'b0; e_an = 4'd0;
        end else begin
            e_seg_b = blank ? 7'd0 : ref_seg(nib, 1'b0);
            e_seg_h = blank ? 7'd0 : ref_seg(nib, 1'b1);
            e_dp    = m_dp[idx];
            e_an    = (cur_cnt() < BLANK_CYC) ? 4'd0 : 4'(1 << idx);
        end
        @(posedge clk);
        if (rst) begin
            m_shadow = 16'd0;
            m_dp     = 4'd0;
            m_tick   = 0;
        end else begin
            if (load) begin
                m_shadow = din;
                m_dp     = dp_in;
            end
            m_tick = (m_tick + 1) % PERIOD;
        end
        #1;
        chk("bcd_seg", {1'b0, seg_b}, {1'b0, e_seg_b});
        chk("bcd_dp",  {7'd0, dp_b},  {7'd0, e_dp});
        chk("bcd_an",  {4'd0, an_b},  {4'd0, e_an});
        chk("hex_seg", {1'b0, seg_h}, {1'b0, e_seg_h});
        chk("hex_an",  {4'd0, an_h},  {4'd0, e_an});
        chk("al_seg",  {1'b0, seg_a}, {1'b0, ~e_seg_b});
        chk("al_dp",   {7'd0, dp_a},  {7'd0, ~e_dp});
        chk("al_an",   {4'd0, an_a},  {4'd0, ~e_an});
    endtask

    // Step until the outputs show digit d in its active (non-blank) part of the slot.
    task automatic go_slot(input int d);
        int n;
        n = 0;
        while (!(cur_idx() == d && cur_cnt() == BLANK_CYC) && n < 4 * PERIOD) begin
            step();
            n++;
        end
        if (n >= 4 * PERIOD) chk("go_slot_timeout", 8'(n), 8'(4 * PERIOD - 1));
        step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        din   = d;
        dp_in = p;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        m_shadow    = 16'd0;
        m_dp        = 4'd0;
        m_tick      = 0;
        rst   = 1'b1;
        din   = 16'd0;
        dp_in = 4'd0;
        load  = 1'b0;
        lz_en = 1'b0;

        // Reset and the first scan slots.
        repeat (3) step();
        chk("rst_seg", {1'b0, seg_b}, 8'h00);
        chk("rst_an_al", {4'd0, an_a}, 8'h0F);
        rst = 1'b0;
        step();
        chk("scan_blank0", {4'd0, an_b}, 8'h00);
        repeat (3) begin
            step();
            chk("scan_dig0", {4'd0, an_b}, 8'h01);
        end
        step();
        chk("scan_blank1", {4'd0, an_b}, 8'h00);
        step();
        chk("scan_dig1", {4'd0, an_b}, 8'h02);
        go_slot(3);
        chk("scan_dig3", {4'd0, an_b}, 8'h08);
        go_slot(0);
        chk("scan_wrap", {4'd0, an_b}, 8'h01);

        // Decode sweep.
        do_load(16'h3210, 4'b0100);
        go_slot(0);
        chk("dec_d0_seg", {1'b0, seg_b}, 8'h7E);
        chk("dec_d0_dp", {7'd0, dp_b}, 8'h00);
        go_slot(2);
        chk("dec_d2_seg", {1'b0, seg_b}, 8'h6D);
        chk("dec_d2_dp", {7'd0, dp_b}, 8'h01);
        go_slot(3);
        chk("dec_d3_seg", {1'b0, seg_b}, 8'h79);

        // Hex vs BCD.
        do_load(16'hFA00, 4'b0000);
        go_slot(2);
        chk("bcd_A", {1'b0, seg_b}, 8'h01);
        chk("hex_A", {1'b0, seg_h}, 8'h77);
        go_slot(3);
        chk("bcd_F", {1'b0, seg_b}, 8'h01);
        chk("hex_F", {1'b0, seg_h}, 8'h47);

        // Leading-zero blanking.
        lz_en = 1'b1;
        do_load(16'h0050, 4'b1000);
        go_slot(3);
        chk("lz_d3_seg", {1'b0, seg_b}, 8'h00);
        chk("lz_d3_dp", {7'd0, dp_b}, 8'h01);
        go_slot(0);
        chk("lz_d0", {1'b0, seg_b}, 8'h7E);
        go_slot(1);
        chk("lz_d1", {1'b0, seg_b}, 8'h5B);
        go_slot(2);
        chk("lz_d2", {1'b0, seg_b}, 8'h00);
        lz_en = 1'b0;
        go_slot(3);
        chk("nolz_d3", {1'b0, seg_b}, 8'h7E);

        // Load on the slot-advance edge.
        n = 0;
        while (cur_cnt() != CLK_DIV - 1 && n < PERIOD) begin
            step();
            n++;
        end
        do_load(16'h8888, 4'b0000);
        din = 16'h1234;
        step();
        chk("collide_seg", {1'b0, seg_b}, 8'h7F);
        go_slot(2);
        chk("hold_seg", {1'b0, seg_b}, 8'h7F);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 3) == 0);
            din   = 16'($urandom);
            dp_in = 4'($urandom);
            lz_en = 1'($urandom);
            step();
        end
        rst  = 1'b0;
        load = 1'b0;

        // Reset in the middle of digit 2's slot on the active-low variant.
        do_load(16'h4321, 4'b0110);
        go_slot(2);
        rst = 1'b1;
        step();
        chk("al_rst_seg", {1'b0, seg_a}, 8'h7F);
        chk("al_rst_an", {4'd0, an_a}, 8'h0F);
        chk("al_rst_dp", {7'd0, dp_a}, 8'h01);
        rst = 1'b0;
        step();
        chk("al_restart_blank", {4'd0, an_a}, 8'h0F);
        step();
        chk("al_restart_d0", {4'd0, an_a}, 8'h0E);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
